// File: rtl/fetch_stage.sv
// Instruction fetch stage: busio read port, 2-entry prefetch queue and
// fetch->decode register, with redirect and stale-read discard.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        invalidate,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        fetch_request,
    output logic [31:0] fetch_address,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic [31:0] instruction_decode,
    output logic [31:0] pc_decode,
    output logic        valid_decode
);

    typedef enum logic {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    localparam logic [31:0] RV  = RESET_VECTOR & ~32'h3;
    localparam logic [31:0] NOP = 32'h00000013;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    entry_t      fifo [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // Gated by reset so busio sees the request drop as soon as reset asserts
    assign fetch_request = reset && (state == DRAIN || count != 2'd2);
    assign fetch_address = (state == DRAIN) ? drain_addr : pc;
    assign fetch_ready   = (count != 2'd0);

    assign push = (state == RUN) && fetch_request && fetch_ack
                  && !redirect_valid;
    assign pop  = fetch_ready && !stall && !invalidate && !redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= RUN;
            pc                 <= RV;
            drain_addr         <= RV;
            count              <= 2'd0;
            rd_ptr             <= 1'b0;
            wr_ptr             <= 1'b0;
            fifo[0]            <= '0;
            fifo[1]            <= '0;
            valid_decode       <= 1'b0;
            instruction_decode <= NOP;
            pc_decode          <= 32'h0;
        end else begin
            if (redirect_valid) begin
                pc     <= redirect_address & ~32'h3;
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                // A read still in flight must finish before the new stream
                if (state == RUN && fetch_request && !fetch_ack) begin
                    state      <= DRAIN;
                    drain_addr <= pc;
                end else if (state == DRAIN && fetch_ack) begin
                    state <= RUN;
                end
            end else begin
                if (state == DRAIN && fetch_ack)
                    state <= RUN;
                if (push) begin
                    fifo[wr_ptr] <= '{pc: pc, insn: fetch_data};
                    wr_ptr       <= !wr_ptr;
                    pc           <= pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= !rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            if (invalidate || redirect_valid) begin
                valid_decode <= 1'b0;
            end else if (!stall) begin
                valid_decode <= fetch_ready;
                if (fetch_ready) begin
                    instruction_decode <= fifo[rd_ptr].insn;
                    pc_decode          <= fifo[rd_ptr].pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table, scoreboard of the
// instruction stream seen by decode, and directed redirect/reset cases.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        invalidate;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [31:0] instruction_decode;
    logic [31:0] pc_decode;
    logic        valid_decode;

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .invalidate         (invalidate),
        .redirect_valid     (redirect_valid),
        .redirect_address   (redirect_address),
        .fetch_request      (fetch_request),
        .fetch_address      (fetch_address),
        .fetch_ack          (fetch_ack),
        .fetch_data         (fetch_data),
        .fetch_ready        (fetch_ready),
        .instruction_decode (instruction_decode),
        .pc_decode          (pc_decode),
        .valid_decode       (valid_decode)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          bus_delay = 0;
    int          wcnt = 0;
    logic [31:0] held;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        rdy;
        logic        vld;
        logic [31:0] pcd;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req"}, {31'b0, fetch_request}, 32'd0);
        chk({p, "_addr"}, fetch_address, RV);
        chk({p, "_rdy"}, {31'b0, fetch_ready}, 32'd0);
        chk({p, "_vld"}, {31'b0, valid_decode}, 32'd0);
        chk({p, "_ins"}, instruction_decode, 32'h00000013);
        chk({p, "_pcd"}, pc_decode, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int delay);
        step();
        reset          = 1'b0;
        stall          = 1'b0;
        invalidate     = 1'b0;
        redirect_valid = 1'b0;
        bus_delay      = delay;
        step();
        exp_q.delete();
        reset = 1'b1;
    endtask

    // Bus responder and decode-side scoreboard
    always @(negedge clk) begin
        if (fetch_request) begin
            if (wcnt != 0)
                chk("addr_hold", fetch_address, held);
            held = fetch_address;
            if (wcnt >= bus_delay) begin
                fetch_ack  = 1'b1;
                fetch_data = mem(fetch_address);
                wcnt       = 0;
            end else begin
                fetch_ack  = 1'b0;
                fetch_data = 32'h0;
                wcnt++;
            end
        end else begin
            fetch_ack = 1'b0;
            wcnt      = 0;
        end
        if (reset && valid_decode && !stall && !invalidate &&
            !redirect_valid && exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", pc_decode, e);
            chk("sb_ins", instruction_decode, mem(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        logic found;
        tbl[0]  = '{1'b0, 1'b1, RV,         1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, RV + 32'h4,  1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, RV + 32'h8,  1'b1, 1'b1, RV};
        tbl[3]  = '{1'b1, 1'b1, RV + 32'hC,  1'b1, 1'b1, RV + 32'h4};
        tbl[4]  = '{1'b1, 1'b0, RV + 32'h10, 1'b1, 1'b1, RV + 32'h4};
        tbl[5]  = '{1'b1, 1'b0, RV + 32'h10, 1'b1, 1'b1, RV + 32'h4};
        tbl[6]  = '{1'b1, 1'b0, RV + 32'h10, 1'b1, 1'b1, RV + 32'h4};
        tbl[7]  = '{1'b1, 1'b0, RV + 32'h10, 1'b1, 1'b1, RV + 32'h4};
        tbl[8]  = '{1'b0, 1'b0, RV + 32'h10, 1'b1, 1'b1, RV + 32'h4};
        tbl[9]  = '{1'b0, 1'b1, RV + 32'h10, 1'b1, 1'b1, RV + 32'h8};
        tbl[10] = '{1'b0, 1'b1, RV + 32'h14, 1'b1, 1'b1, RV + 32'hC};
        tbl[11] = '{1'b0, 1'b1, RV + 32'h18, 1'b1, 1'b1, RV + 32'h10};
        tbl[12] = '{1'b0, 1'b1, RV + 32'h1C, 1'b1, 1'b1, RV + 32'h14};

        reset            = 1'b1;
        stall            = 1'b0;
        invalidate       = 1'b0;
        redirect_valid   = 1'b0;
        redirect_address = 32'h0;
        fetch_ack        = 1'b0;
        fetch_data       = 32'h0;
        #2 reset = 1'b0;
        #2 chk_reset("rst0");

        // Streaming with a 5-cycle stall
        step();
        for (int i = 0; i < 6; i++)
            exp_q.push_back(RV + 32'(4 * i));
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            stall = tbl[i].stall;
            @(negedge clk);
            chk($sformatf("t1_req[%0d]", i), {31'b0, fetch_request},
                {31'b0, tbl[i].req});
            chk($sformatf("t1_addr[%0d]", i), fetch_address, tbl[i].addr);
            chk($sformatf("t1_rdy[%0d]", i), {31'b0, fetch_ready},
                {31'b0, tbl[i].rdy});
            chk($sformatf("t1_vld[%0d]", i), {31'b0, valid_decode},
                {31'b0, tbl[i].vld});
            if (tbl[i].vld)
                chk($sformatf("t1_pcd[%0d]", i), pc_decode, tbl[i].pcd);
            step();
        end
        stall = 1'b1;
        @(negedge clk);
        chk("t1_sb_left", exp_q.size(), 32'd0);

        // Redirect during a slow outstanding read
        restart(3);
        @(negedge clk);
        chk("t3_req0", {31'b0, fetch_request}, 32'd1);
        chk("t3_addr0", fetch_address, RV);
        step();
        redirect_valid   = 1'b1;
        redirect_address = 32'h00000100;
        exp_q.push_back(32'h00000100);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_addr2", fetch_address, RV);
        step();
        @(negedge clk);
        chk("t3_addr3", fetch_address, RV);
        step();
        @(negedge clk);
        chk("t3_addr4", fetch_address, 32'h00000100);
        chk("t3_req4", {31'b0, fetch_request}, 32'd1);
        chk("t3_rdy4", {31'b0, fetch_ready}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            @(negedge clk);
            if (valid_decode)
                found = 1'b1;
        end
        chk("t3_found", {31'b0, found}, 32'd1);
        if (found)
            chk("t3_pcd", pc_decode, 32'h00000100);

        // Redirect coincident with an ack
        restart(0);
        step();
        step();
        step();
        redirect_valid   = 1'b1;
        redirect_address = 32'h00000203;
        exp_q.push_back(32'h00000200);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_addr", fetch_address, 32'h00000200);
        chk("t4_req", {31'b0, fetch_request}, 32'd1);
        chk("t4_rdy", {31'b0, fetch_ready}, 32'd0);
        chk("t4_vld", {31'b0, valid_decode}, 32'd0);
        step();
        @(negedge clk);
        chk("t4_rdy5", {31'b0, fetch_ready}, 32'd1);
        chk("t4_vld5", {31'b0, valid_decode}, 32'd0);
        step();
        @(negedge clk);
        chk("t4_vld6", {31'b0, valid_decode}, 32'd1);
        chk("t4_pcd6", pc_decode, 32'h00000200);
        chk("t4_ins6", instruction_decode, mem(32'h00000200));

        // Invalidate with a full queue
        restart(0);
        step();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        stall      = 1'b0;
        invalidate = 1'b1;
        @(negedge clk);
        chk("t5_req5", {31'b0, fetch_request}, 32'd0);
        chk("t5_rdy5", {31'b0, fetch_ready}, 32'd1);
        step();
        invalidate = 1'b0;
        exp_q.push_back(RV + 32'h8);
        exp_q.push_back(RV + 32'hC);
        @(negedge clk);
        chk("t5_vld6", {31'b0, valid_decode}, 32'd0);
        chk("t5_rdy6", {31'b0, fetch_ready}, 32'd1);
        chk("t5_req6", {31'b0, fetch_request}, 32'd0);
        step();
        @(negedge clk);
        chk("t5_vld7", {31'b0, valid_decode}, 32'd1);
        chk("t5_pcd7", pc_decode, RV + 32'h8);
        step();
        @(negedge clk);
        chk("t5_pcd8", pc_decode, RV + 32'hC);
        chk("t5_ins8", instruction_decode, mem(RV + 32'hC));
        step();
        stall = 1'b1;
        step();
        @(negedge clk);
        chk("t6_full_rdy", {31'b0, fetch_ready}, 32'd1);
        chk("t6_full_req", {31'b0, fetch_request}, 32'd0);

        // Asynchronous reset mid-stream
        #2 reset = 1'b0;
        #1 chk_reset("t6_rst");
        step();
        exp_q.delete();
        stall = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_req0", {31'b0, fetch_request}, 32'd1);
        chk("t6_addr0", fetch_address, RV);
        chk("t6_rdy0", {31'b0, fetch_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("t6_addr1", fetch_address, RV + 32'h4);
        chk("t6_rdy1", {31'b0, fetch_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
